// File: rtl/enemy_fire_arbiter_pkg.sv
// Shared game package: slot/ship counts, screen and spawn constants,
// fire arbiter state encoding and the round-robin pick helper.
package enemy_fire_arbiter_pkg;

  localparam int unsigned NUM_SLOTS = 2;
  localparam int unsigned NUM_SHIPS = 3;
  localparam int unsigned X_W       = 10;
  localparam int unsigned Y_W       = 9;

  localparam int unsigned SCREEN_W  = 640;
  localparam int unsigned SCREEN_H  = 480;

  localparam logic [X_W-1:0] SPAWN_A_X = 10'd96;
  localparam logic [X_W-1:0] SPAWN_B_X = 10'd304;
  localparam logic [X_W-1:0] SPAWN_C_X = 10'd512;
  localparam logic [Y_W-1:0] SPAWN_Y   = 9'd32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_LAUNCH,
    ST_COOLDOWN
  } fire_state_e;

  // Round-robin pick: search starts at the ship after the last grant,
  // wrapping C back to A. Returns one-hot, or zero when nobody requests.
  function automatic logic [NUM_SHIPS-1:0] rr_pick(
    input logic [NUM_SHIPS-1:0] req,
    input logic [NUM_SHIPS-1:0] last
  );
    logic [NUM_SHIPS-1:0] pick;
    case (last)
      3'b001:  pick = req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000;
      3'b010:  pick = req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000;
      default: pick = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/enemy_fire_arbiter_slot.sv
// One enemy bullet slot: load at the muzzle, move down per frame,
// kill on hit or when the bullet leaves the screen.
module enemy_bullet_slot
  import enemy_fire_arbiter_pkg::*;
#(
  parameter int unsigned BULLET_SPEED = 4,
  parameter int unsigned Y_LIMIT      = 480
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load_i,
  input  logic           move_i,
  input  logic           clear_i,
  input  logic [X_W-1:0] load_x_i,
  input  logic [Y_W-1:0] load_y_i,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic           active_o
);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           active_q, active_d;
  logic [Y_W:0]   y_sum;

  // One extra bit so the downward step can never wrap the 9-bit y.
  assign y_sum = {1'b0, y_q} + (Y_W+1)'(BULLET_SPEED);

  // Next slot contents: hit kill beats load, load beats movement.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    active_d = active_q;
    if (clear_i) begin
      active_d = 1'b0;
    end else if (load_i) begin
      x_d      = load_x_i;
      y_d      = load_y_i;
      active_d = 1'b1;
    end else if (move_i && active_q) begin
      if (y_sum[Y_W] || (32'(y_sum) >= Y_LIMIT)) begin
        active_d = 1'b0;
      end else begin
        y_d = y_sum[Y_W-1:0];
      end
    end
  end

  // Slot registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q      <= '0;
      y_q      <= '0;
      active_q <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      active_q <= active_d;
    end
  end

  assign x_o      = x_q;
  assign y_o      = y_q;
  assign active_o = active_q;

endmodule

// File: rtl/enemy_fire_arbiter.sv
// Enemy fire arbiter: round-robin choice among three ships, launches
// into the lowest free bullet slot, then waits a frame-based cooldown.
module enemy_fire_arbiter
  import enemy_fire_arbiter_pkg::*;
#(
  parameter int unsigned BULLET_SPEED = 4,
  parameter int unsigned COOLDOWN     = 30,
  parameter int unsigned Y_LIMIT      = 480,
  parameter int unsigned X_OFFSET     = 8,
  parameter int unsigned Y_OFFSET     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic [NUM_SHIPS-1:0] fire_req,
  input  logic [X_W-1:0]       enemy_A_x,
  input  logic [X_W-1:0]       enemy_B_x,
  input  logic [X_W-1:0]       enemy_C_x,
  input  logic [Y_W-1:0]       enemy_A_y,
  input  logic [Y_W-1:0]       enemy_B_y,
  input  logic [Y_W-1:0]       enemy_C_y,
  input  logic [NUM_SLOTS-1:0] hit_clear,
  output logic [NUM_SHIPS-1:0] fire_grant,
  output logic [X_W-1:0]       bullet0_x,
  output logic [X_W-1:0]       bullet1_x,
  output logic [Y_W-1:0]       bullet0_y,
  output logic [Y_W-1:0]       bullet1_y,
  output logic [NUM_SLOTS-1:0] bullet_active
);

  localparam int unsigned CNT_W = $clog2(COOLDOWN + 2);

  fire_state_e          state_q, state_d;
  logic [NUM_SHIPS-1:0] last_grant_q, last_grant_d;
  logic [NUM_SHIPS-1:0] pick_q, pick_d;
  logic [CNT_W-1:0]     cooldown_q, cooldown_d;

  logic [NUM_SLOTS-1:0] slot_active;
  logic [NUM_SLOTS-1:0] free_mask;
  logic [NUM_SLOTS-1:0] launch_sel;
  logic [NUM_SLOTS-1:0] slot_load;
  logic [X_W-1:0]       slot_x [NUM_SLOTS];
  logic [Y_W-1:0]       slot_y [NUM_SLOTS];

  logic [X_W-1:0]       ship_x;
  logic [Y_W-1:0]       ship_y;
  logic [X_W-1:0]       load_x;
  logic [Y_W-1:0]       load_y;

  // A slot being hit this cycle is never a launch target.
  assign free_mask  = ~slot_active & ~hit_clear;
  assign launch_sel = free_mask & (~free_mask + 1'b1);

  // Muzzle position of the ship chosen during arbitration.
  always_comb begin
    ship_x = enemy_A_x;
    ship_y = enemy_A_y;
    if (pick_q[1]) begin
      ship_x = enemy_B_x;
      ship_y = enemy_B_y;
    end else if (pick_q[2]) begin
      ship_x = enemy_C_x;
      ship_y = enemy_C_y;
    end
  end

  assign load_x = X_W'(ship_x + X_OFFSET);
  assign load_y = Y_W'(ship_y + Y_OFFSET);

  // FSM state and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 3'b100;
      pick_q       <= '0;
      cooldown_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      pick_q       <= pick_d;
      cooldown_q   <= cooldown_d;
    end
  end

  // Next-state logic: request check, arbitration, launch, frame cooldown.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    pick_d       = pick_q;
    cooldown_d   = cooldown_q;
    case (state_q)
      ST_IDLE: begin
        if ((fire_req != '0) && !(&slot_active)) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (fire_req == '0) begin
          state_d = ST_IDLE;
        end else begin
          pick_d  = rr_pick(fire_req, last_grant_q);
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (|free_mask) begin
          last_grant_d = pick_q;
          cooldown_d   = CNT_W'(COOLDOWN);
          state_d      = ST_COOLDOWN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COOLDOWN: begin
        if (frame_tick) begin
          if (cooldown_q <= CNT_W'(1)) begin
            cooldown_d = '0;
            state_d    = ST_IDLE;
          end else begin
            cooldown_d = cooldown_q - 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Grant pulse and slot load; reset suppresses both in the same cycle.
  always_comb begin
    fire_grant = '0;
    slot_load  = '0;
    if ((state_q == ST_LAUNCH) && !reset && (|free_mask)) begin
      fire_grant = pick_q;
      slot_load  = launch_sel;
    end
  end

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    enemy_bullet_slot #(
      .BULLET_SPEED(BULLET_SPEED),
      .Y_LIMIT     (Y_LIMIT)
    ) u_slot (
      .clk     (clk),
      .reset   (reset),
      .load_i  (slot_load[gi]),
      .move_i  (frame_tick),
      .clear_i (hit_clear[gi]),
      .load_x_i(load_x),
      .load_y_i(load_y),
      .x_o     (slot_x[gi]),
      .y_o     (slot_y[gi]),
      .active_o(slot_active[gi])
    );
  end

  assign bullet0_x     = slot_x[0];
  assign bullet0_y     = slot_y[0];
  assign bullet1_x     = slot_x[1];
  assign bullet1_y     = slot_y[1];
  assign bullet_active = slot_active;

endmodule

// File: doc/enemy_fire_arbiter.md
ENEMY_FIRE_ARBITER -- requirements
Module: enemy_fire_arbiter

Interface
REQ-001 SHALL have parameter BULLET_SPEED, default 4, meaning pixels added to bullet y per frame_tick.
REQ-002 SHALL have parameter COOLDOWN, default 30, meaning frame_ticks between consecutive grants.
REQ-003 SHALL have parameter Y_LIMIT, default 480, meaning the first y at which a bullet is off screen.
REQ-004 SHALL have parameters X_OFFSET, default 8, and Y_OFFSET, default 16, meaning the muzzle offset from the ship origin.
REQ-005 clk  input  1  system clock; single clock domain.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 frame_tick  input  1  one-cycle pulse, once per video frame.
REQ-008 fire_req  input  3  per-ship fire request: bit0=A, bit1=B, bit2=C; level-sensitive.
REQ-009 enemy_A_x/enemy_B_x/enemy_C_x  input  10 each  ship x positions.
REQ-010 enemy_A_y/enemy_B_y/enemy_C_y  input  9 each  ship y positions.
REQ-011 hit_clear  input  2  per-slot collision kill, one-cycle pulse.
REQ-012 fire_grant  output  3  one-hot, one-cycle pulse naming the ship that fired.
REQ-013 bullet0_x, bullet1_x  output  10 each; bullet0_y, bullet1_y  output  9 each; bullet_active  output  2  slot positions and valid flags.

Function
REQ-014 SHALL run an FSM with states IDLE, ARB, LAUNCH and COOLDOWN.
REQ-015 IDLE -> ARB when fire_req != 0 and at least one slot is inactive; otherwise the FSM stays in IDLE.
REQ-016 ARB SHALL pick the requester by round-robin, starting the search at the bit after last_grant (wrapping C->A), and SHALL go to LAUNCH; if fire_req has dropped to 0, ARB SHALL return to IDLE.
REQ-017 LAUNCH SHALL assert fire_grant for exactly one cycle, load the lowest-index inactive slot with x = ship_x + X_OFFSET and y = ship_y + Y_OFFSET, set that slot active, update last_grant, load cooldown_cnt = COOLDOWN, and go to COOLDOWN.
REQ-018 COOLDOWN SHALL decrement cooldown_cnt on each frame_tick and go to IDLE on the frame_tick that reaches 0.
REQ-019 Latency from fire_req assertion in IDLE to the fire_grant pulse SHALL be exactly 2 cycles (IDLE->ARB->LAUNCH).
REQ-020 Slot-free evaluation SHALL use registered bullet_active; a slot freed in a cycle is usable from the next cycle.
REQ-021 On frame_tick, each active slot SHALL compute y + BULLET_SPEED in 10 bits; if the result is >= Y_LIMIT, the slot SHALL deactivate, otherwise y SHALL update. The add SHALL never wrap 9 bits.
REQ-022 A hit_clear bit SHALL deactivate its slot in the same cycle, with priority over frame_tick movement.
REQ-023 A launch SHALL not target a slot whose hit_clear is asserted in the LAUNCH cycle; if no other slot is free, the grant SHALL be withheld and the FSM SHALL return to IDLE.
REQ-024 frame_tick in the LAUNCH cycle SHALL move the other slots but SHALL not move the newly loaded slot.
REQ-025 Inactive slots SHALL hold their last x and y values.

Reset
REQ-026 While reset is high, state = IDLE, bullet_active = 0, fire_grant = 0, cooldown_cnt = 0, last_grant = C (so that A has first priority), and all bullet x and y = 0.
REQ-027 Reset asserted mid-LAUNCH or mid-COOLDOWN SHALL win; no grant pulse SHALL appear in that cycle.

Structure
REQ-028 FSM state encodings, slot count (2) and screen constants SHALL reside in the shared game package, alongside the enemy spawn constants.
REQ-029 Bullet motion SHALL be one sub-module, enemy_bullet_slot (load, move, clear, active), instantiated twice.

Verification
REQ-030 Verification SHALL include a single shot: reset, then fire_req=001 with ship A at (200,40) -> fire_grant=001 exactly 2 cycles later, bullet0 = (208,56) and active.
REQ-031 Verification SHALL include round-robin: fire_req=111 held for 3 grants with cooldown expiring between them -> grants A, B, C in that order.
REQ-032 Verification SHALL include slots full: two bullets active and fire_req held -> no grant until a slot clears, then the grant targets the cleared slot.
REQ-033 Verification SHALL include off-screen removal: bullet y=472 with BULLET_SPEED=4, first frame_tick -> y=476; second frame_tick -> inactive.
REQ-034 Verification SHALL include hit_clear and frame_tick in the same cycle on slot 0 -> slot 0 inactive and y unchanged.
REQ-035 Verification SHALL include reset asserted during COOLDOWN with cnt=12 -> state IDLE, bullet_active=00, and the next grant goes to A.
